ibex_l2_rf_ctrl: RTL

Sequencer and arbiter for the single-port L2 register bank (words 1..NumWords-1, word 0 unused). It performs bulk save (core RF -> L2) and restore (L2 -> core RF) transfers, one register per cycle, and time-shares the L2 port with a single-word direct-access requester. It sits between the core register file's spare access port, the L2 bank, and the debug/context-switch logic that issues commands.

---
 rtl/ibex_l2_rf_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/ibex_l2_rf_ctrl.sv
// ibex_l2_rf_ctrl: sequences bulk save/restore transfers between the core
// register file and the single-port L2 register bank, and time-shares the
// L2 port with a single-word direct-access requester.
//
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   cmd_valid_i/cmd_op_i      transfer command (op 0 = save, 1 = restore)
//   cmd_ready_o               command accepted this cycle
//   busy_o, done_o            transfer in progress / one-cycle completion pulse
//   crf_*                     core RF spare port (rdata combinational from addr)
//   l2_*                      L2 bank port (rdata combinational from addr)
//   dir_*                     direct single-word access, zero latency on grant
module ibex_l2_rf_ctrl #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned NumWords  = 24
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cmd_valid_i,
    input  logic                 cmd_op_i,
    output logic                 cmd_ready_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [4:0]           crf_addr_o,
    output logic                 crf_we_o,
    output logic [DataWidth-1:0] crf_wdata_o,
    input  logic [DataWidth-1:0] crf_rdata_i,
    output logic [4:0]           l2_addr_o,
    output logic                 l2_we_o,
    output logic [DataWidth-1:0] l2_wdata_o,
    input  logic [DataWidth-1:0] l2_rdata_i,
    input  logic                 dir_req_i,
    input  logic                 dir_we_i,
    input  logic [4:0]           dir_addr_i,
    input  logic [DataWidth-1:0] dir_wdata_i,
    output logic                 dir_gnt_o,
    output logic [DataWidth-1:0] dir_rdata_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [4:0] LastIdx = 5'(NumWords - 1);

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       prio_q, prio_d;
    logic       op_q, op_d;

    logic is_idle;
    logic cmd_win;
    logic dir_win;
    logic dir_oor;

    assign is_idle = (state_q == IDLE);

    // prio_q = 0 favours the command, 1 favours direct; it flips toward the
    // loser after every grant so neither requester can starve the other.
    assign cmd_win = cmd_valid_i & (~dir_req_i | ~prio_q);
    assign dir_win = dir_req_i & (~cmd_valid_i | prio_q);

    // Word 0 is unused; the 6-bit compare keeps NumWords = 32 legal.
    assign dir_oor = (dir_addr_i == 5'd0) ||
                     ({1'b0, dir_addr_i} >= 6'(NumWords));

    assign cmd_ready_o = is_idle & cmd_win;
    assign dir_gnt_o   = is_idle & dir_win;
    assign busy_o      = ~is_idle;
    assign done_o      = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prio_d  = prio_q;
        op_d    = op_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_win) begin
                    op_d    = cmd_op_i;
                    cnt_d   = 5'd1;
                    prio_d  = 1'b1;
                    state_d = XFER;
                end else if (dir_win) begin
                    prio_d = 1'b0;
                end
            end
            XFER: begin
                if (cnt_q == LastIdx) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 5'd1;
            prio_q  <= 1'b0;
            op_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prio_q  <= prio_d;
            op_q    <= op_d;
        end
    end

    // Port muxing: the L2 port belongs to the transfer in XFER and to the
    // direct requester only on a grant; everything idles at zero otherwise.
    always_comb begin
        crf_addr_o  = '0;
        crf_we_o    = 1'b0;
        crf_wdata_o = '0;
        l2_addr_o   = '0;
        l2_we_o     = 1'b0;
        l2_wdata_o  = '0;
        dir_rdata_o = '0;
        if (state_q == XFER) begin
            crf_addr_o = cnt_q;
            l2_addr_o  = cnt_q;
            if (op_q) begin
                crf_we_o    = 1'b1;
                crf_wdata_o = l2_rdata_i;
            end else begin
                l2_we_o    = 1'b1;
                l2_wdata_o = crf_rdata_i;
            end
        end else if (dir_gnt_o) begin
            l2_addr_o   = dir_addr_i;
            l2_we_o     = dir_we_i & ~dir_oor;
            l2_wdata_o  = dir_wdata_i;
            dir_rdata_o = dir_oor ? '0 : l2_rdata_i;
        end
    end

endmodule
